// File: rtl/key_evt_pkg.sv
// Shared types, PIO register map and helpers for the key event sequencer.
package key_evt_pkg;

  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_KEYS = 4;
  localparam int unsigned KEY_W    = 2;

  // PIO register map
  localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [3:0] {
    INIT_MASK,
    INIT_CLR,
    IDLE,
    RD,
    RD_WAIT,
    CLR,
    PUSH,
    HOLD,
    HOLD_CLR
  } state_t;

  // One Avalon-MM access as driven onto the PIO slave port
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
  } avm_req_t;

  // Index of the lowest set bit; 0 when no bit is set
  function automatic logic [KEY_W-1:0] lowest_set(input logic [MAX_KEYS-1:0] v);
    lowest_set = '0;
    for (int i = int'(MAX_KEYS) - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = KEY_W'(i);
    end
  endfunction

endpackage

// File: rtl/key_evt_if.sv
// Avalon-MM link between the sequencer and the key PIO slave port, plus the PIO irq.
interface key_evt_if;
  import key_evt_pkg::*;

  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              key_irq;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata, key_irq
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata, key_irq
  );

endinterface

// File: rtl/key_evt_fifo.sv
// Small synchronous FIFO for key events; head entry is visible on rdata_c.
module key_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c,
  output logic             drop_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // A pop on a full FIFO frees the slot the simultaneous push needs
  assign empty_c = (count == '0);
  assign full_c  = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);
  assign drop_c  = push && !do_push;
  assign rdata_c = mem[rd_ptr];

  // Storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/key_event_sequencer.sv
// Sole Avalon-MM master of the key PIO: initialises it, services its irq,
// debounces with a hold-off and queues one event per pressed key.
module key_event_sequencer
  import key_evt_pkg::*;
#(
  parameter int unsigned          NKEYS          = 4,
  parameter logic [MAX_KEYS-1:0]  KEY_MASK       = 4'hF,
  parameter int unsigned          HOLDOFF_CYCLES = 500000,
  parameter int unsigned          CNT_W          = 20,
  parameter int unsigned          FIFO_DEPTH     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  key_evt_if.master        avm,
  output logic             evt_valid,
  output logic [KEY_W-1:0] evt_key,
  input  logic             evt_ready,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic             busy
);

  localparam logic [MAX_KEYS-1:0] NKEYS_SEL = MAX_KEYS'((32'd1 << NKEYS) - 32'd1);

  state_t              state;
  state_t              state_next;
  avm_req_t            req_q;
  avm_req_t            req_next;
  logic [MAX_KEYS-1:0] cap_q;
  logic [MAX_KEYS-1:0] cap_next;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_next;
  logic                push_c;
  logic [KEY_W-1:0]    push_key_c;
  logic                fifo_empty_c;
  logic                fifo_drop_c;
  logic                fifo_full_unused;
  logic                rd_unused;

  assign avm.avm_address    = req_q.address;
  assign avm.avm_chipselect = req_q.chipselect;
  assign avm.avm_write_n    = req_q.write_n;
  assign avm.avm_writedata  = req_q.writedata;
  assign rd_unused          = ^avm.avm_readdata[DATA_W-1:MAX_KEYS];
  assign evt_valid          = !fifo_empty_c;

  // Next state, next bus access, capture/counter updates and push request.
  // RD/CLR/HOLD_CLR accesses are registered as their state is entered; the
  // two init writes trail their states by one cycle because the reset state
  // itself leaves the bus idle.
  always_comb begin
    state_next           = state;
    req_next.address     = ADDR_EDGE;
    req_next.chipselect  = 1'b0;
    req_next.write_n     = 1'b1;
    req_next.writedata   = '0;
    cap_next             = cap_q;
    cnt_next             = cnt_q;
    push_c               = 1'b0;
    push_key_c           = lowest_set(cap_q);

    unique case (state)
      INIT_MASK: begin
        req_next.address    = ADDR_MASK;
        req_next.chipselect = 1'b1;
        req_next.write_n    = 1'b0;
        req_next.writedata  = DATA_W'(KEY_MASK);
        state_next          = INIT_CLR;
      end
      INIT_CLR: begin
        req_next.chipselect = 1'b1;
        req_next.write_n    = 1'b0;
        state_next          = IDLE;
      end
      IDLE: begin
        // irq is stale while the trailing init clear is still on the bus
        if (avm.key_irq && req_q.write_n) begin
          req_next.chipselect = 1'b1;
          state_next          = RD;
        end
      end
      RD: begin
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        cap_next            = avm.avm_readdata[MAX_KEYS-1:0] & KEY_MASK & NKEYS_SEL;
        req_next.chipselect = 1'b1;
        req_next.write_n    = 1'b0;
        state_next          = CLR;
      end
      CLR: begin
        state_next = PUSH;
      end
      PUSH: begin
        if (cap_q != '0) begin
          push_c   = 1'b1;
          cap_next = cap_q & (cap_q - MAX_KEYS'(1));
        end
        if (cap_next == '0) begin
          cnt_next   = CNT_W'(HOLDOFF_CYCLES - 1);
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          req_next.chipselect = 1'b1;
          req_next.write_n    = 1'b0;
          state_next          = HOLD_CLR;
        end else begin
          cnt_next = cnt_q - CNT_W'(1);
        end
      end
      HOLD_CLR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = INIT_MASK;
      end
    endcase
  end

  // State, bus access, capture and hold-off registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                <= INIT_MASK;
      req_q.address        <= '0;
      req_q.chipselect     <= 1'b0;
      req_q.write_n        <= 1'b1;
      req_q.writedata      <= '0;
      cap_q                <= '0;
      cnt_q                <= '0;
      busy                 <= 1'b1;
    end else begin
      state <= state_next;
      req_q <= req_next;
      cap_q <= cap_next;
      cnt_q <= cnt_next;
      busy  <= (state_next != IDLE);
    end
  end

  // Sticky overflow; a new drop beats a simultaneous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (fifo_drop_c) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  key_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_c),
    .pop     (evt_ready),
    .wdata   (push_key_c),
    .rdata_c (evt_key),
    .full_c  (fifo_full_unused),
    .empty_c (fifo_empty_c),
    .drop_c  (fifo_drop_c)
  );

endmodule

// File: doc/key_event_sequencer.md
Name: key_event_sequencer

Overview:
- Hardware servicing engine for the 4-bit key PIO; acts as sole Avalon-MM master on that PIO's slave port.
- Programs the PIO irq mask, services its interrupt (read edge_capture, clear it), applies a debounce hold-off, and queues one event per pressed key into a small FIFO.
- The consumer (Nios-side register block or local logic) pops key events without touching the PIO.

Parameters:
NKEYS, 4, number of key lines / edge_capture bits serviced (1..4)
KEY_MASK, 4'hF, value written to PIO irq_mask at init
HOLDOFF_CYCLES, 500000, debounce hold-off after each service (10 ms at 50 MHz); must be >= 1
CNT_W, 20, hold-off counter width; must satisfy 2**CNT_W > HOLDOFF_CYCLES
FIFO_DEPTH, 4, event FIFO entries (power of 2, >= 2)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
avm_address  out  2  PIO register select (0 data, 2 irq_mask, 3 edge_capture)
avm_chipselect  out  1  PIO select, one cycle per access
avm_write_n  out  1  active-low write strobe
avm_writedata  out  32  write data
avm_readdata  in  32  PIO readdata, valid 1 cycle after address presented
key_irq  in  1  PIO irq output
evt_valid  out  1  FIFO non-empty
evt_key  out  2  key index at FIFO head
evt_ready  in  1  consumer pop; pop occurs when evt_valid && evt_ready
overflow  out  1  sticky: an event was dropped because FIFO full
ovf_clr  in  1  clears overflow
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset is asynchronous; the design is clocked on clk. Reset values: avm_chipselect 0, avm_write_n 1, avm_address 0, avm_writedata 0, evt_valid 0, evt_key 0, overflow 0, busy 1, FIFO empty, state INIT_MASK.
- Every PIO write is one cycle: chipselect=1, write_n=0, address and writedata driven in the same cycle. A read is one cycle: chipselect=1, write_n=1, address=3. Outside accesses: chipselect=0, write_n=1.
- FSM:
  - INIT_MASK: write addr 2, data {28'b0, KEY_MASK} -> INIT_CLR.
  - INIT_CLR: write addr 3 (discards stale edges) -> IDLE.
  - IDLE: busy=0; keep avm_address=3. If key_irq=1 -> RD.
  - RD: read addr 3 -> RD_WAIT.
  - RD_WAIT: latch cap = avm_readdata[NKEYS-1:0] & KEY_MASK -> CLR.
  - CLR: write addr 3, data 0 (the PIO clears all bits on any write) -> PUSH.
  - PUSH: each cycle, push the lowest set bit index of cap and clear that bit. When cap==0 -> HOLD. If cap==0 on entry, go straight to HOLD.
  - HOLD: load the counter with HOLDOFF_CYCLES-1 on entry; decrement each cycle; at 0 -> HOLD_CLR. key_irq is ignored throughout.
  - HOLD_CLR: write addr 3 (discards bounce edges) -> IDLE.
- Service latency: the key_irq rising cycle is t. Write at t+3, first push at t+4, first evt_valid at t+5.
- FIFO:
  - Registered; evt_key is the head entry.
  - Push when full: entry dropped, overflow<=1, remaining bits still consumed one per cycle.
  - Simultaneous push and pop when full: the pop frees a slot, so the push is accepted and no overflow occurs.
  - Pop when empty: ignored.
- overflow:
  - ovf_clr clears it.
  - If ovf_clr coincides with a new drop, the set wins.
- An edge arriving between RD and CLR is lost by design (the PIO clear is unconditional). This is documented, not corrected.
- Assertion of reset_n low mid-operation aborts any access (chipselect drops immediately) and empties the FIFO. On release, the FSM restarts at INIT_MASK.

Decomposition:
- Package key_evt_pkg:
  - state enum
  - PIO address constants (ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3)
  - priority-encoder function (lowest set bit)
- Sub-module key_evt_fifo: parameterised sync FIFO with push, pop, full, empty, and a drop flag.
- The FSM and hold-off counter stay in the top module.

Test Plan (bench uses HOLDOFF_CYCLES=8, with the real PIO model attached):
- Reset release -> two writes observed, in order: addr2 data 0x0000000F, then addr3; busy falls on the 3rd cycle after release.
- in_port 4'hF -> 4'hE (KEY0 press) -> irq; exactly one event, evt_key=0. The next service is blocked for 8 cycles. A bounce 4'hF->4'hE during HOLD produces no event.
- KEY1 and KEY3 pressed in the same cycle -> events 1 then 3 on consecutive pushes. Read, write, and push timing matches t+1/t+3/t+4.
- evt_ready held 0, then 5 single-key services (keys 0,1,2,3,0) -> FIFO holds 0,1,2,3. overflow=1. ovf_clr pulse -> overflow=0.
- FIFO full while a push coincides with a pop (evt_ready=1) -> no overflow; the new key is appended; count stays 4.
- Assert reset_n low during PUSH with 2 events queued -> evt_valid=0 immediately. After release, the INIT sequence is repeated.
